// File: rtl/cw_clk_pkg.sv
// rtl/cw_clk_pkg.sv - shared types and constants for crypto-clock frequency measurement
package cw_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } meter_state_t;

  localparam int DEFAULT_COUNT_W     = 24;
  localparam int DEFAULT_ARM_TIMEOUT = 1 << 20;

  // Offsets of the bridged result registers in the USB register file
  localparam logic [7:0] FREQ_COUNT_OFS  = 8'h00;
  localparam logic [7:0] FREQ_STATUS_OFS = 8'h04;

  localparam int STATUS_VALID_BIT    = 0;
  localparam int STATUS_BUSY_BIT     = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_TIMEOUT_BIT  = 3;

  // The internal counter must hold both the saturated result and the arm timeout.
  function automatic int meter_cnt_w(int count_w, int arm_timeout);
    int tw;
    tw = $clog2(arm_timeout);
    return (count_w > tw) ? count_w : tw;
  endfunction

endpackage

// File: rtl/toggle_edge_sync.sv
// rtl/toggle_edge_sync.sv - synchronizes a slow toggle into the local clock and flags each transition
module toggle_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic toggle,
  output logic gate_edge
);

  localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES + 1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic       edge_q;
  logic [2:0] fill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle};
      edge_q <= sync_q[SYNC_STAGES-1];
      if (fill_q != FILL_DONE) fill_q <= fill_q + 3'd1;
    end
  end

  // Edges are masked until the chain and edge register hold the post-reset level,
  // so a toggle input sitting high at reset release is not seen as a transition.
  assign gate_edge = (fill_q == FILL_DONE) && (sync_q[SYNC_STAGES-1] ^ edge_q);

endmodule

// File: rtl/cryptoclk_freq_meter.sv
// rtl/cryptoclk_freq_meter.sv - counts crypto-clock cycles across one gate half-period
module cryptoclk_freq_meter
  import cw_clk_pkg::*;
#(
  parameter int COUNT_W     = DEFAULT_COUNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int ARM_TIMEOUT = DEFAULT_ARM_TIMEOUT
) (
  input  logic               crypto_clk,
  input  logic               reset_i,
  input  logic               I_gate_toggle,
  input  logic               I_start,
  input  logic               I_abort,
  input  logic               I_ack,
  output logic [COUNT_W-1:0] O_count,
  output logic               O_valid,
  output logic               O_busy,
  output logic               O_overflow,
  output logic               O_timeout
);

  localparam int              CNT_W    = meter_cnt_w(COUNT_W, ARM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'({COUNT_W{1'b1}});
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_TIMEOUT - 1);

  logic gate_edge;

  meter_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic               tmo_q, tmo_d;

  toggle_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_gate_sync (
    .clk       (crypto_clk),
    .rst       (reset_i),
    .toggle    (I_gate_toggle),
    .gate_edge (gate_edge)
  );

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;

    if (I_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (I_start && !I_abort) begin
            state_d = ST_ARM;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            tmo_d   = 1'b0;
            valid_d = 1'b0;
          end
        end
        ST_ARM: begin
          // An edge arriving on the timeout cycle still starts the measurement.
          if (gate_edge) begin
            state_d = ST_COUNT;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == ARM_LAST) begin
            state_d = ST_DONE;
            tmo_d   = 1'b1;
            count_d = '0;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_COUNT: begin
          if (gate_edge) begin
            state_d = ST_DONE;
            count_d = cnt_q[COUNT_W-1:0];
            valid_d = 1'b1;
          end else if (cnt_q == CNT_SAT) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (I_ack) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_ARM) || (state_d == ST_COUNT);
  end

  assign O_count    = count_q;
  assign O_valid    = valid_q;
  assign O_busy     = busy_q;
  assign O_overflow = ovf_q;
  assign O_timeout  = tmo_q;

endmodule
